// File: rtl/ysyx_pkg.sv
// rtl/ysyx_pkg.sv - RV32 opcodes, ALU/writeback encodings and decoded bundle type
package ysyx_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'b0000,
      ALU_SUB   = 4'b0001,
      ALU_SLL   = 4'b0010,
      ALU_SLT   = 4'b0011,
      ALU_SLTU  = 4'b0100,
      ALU_XOR   = 4'b0101,
      ALU_SRL   = 4'b0110,
      ALU_SRA   = 4'b0111,
      ALU_OR    = 4'b1000,
      ALU_AND   = 4'b1001,
      ALU_BR    = 4'b1010,
      ALU_PASSB = 4'b1110
   } alu_op_t;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_PC4 = 2'd1,
      WB_MEM = 2'd2
   } wb_sel_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rf_wr_en;
      wb_sel_t     rf_wr_sel;
      logic        do_jump;
      logic        is_branch;
      logic        mem_rd;
      logic        mem_wr;
      logic        alu_a_sel;
      logic        alu_b_sel;
      alu_op_t     alu_ctrl;
      logic [2:0]  funct3;
      logic        ebreak;
      logic        illegal;
   } dec_bundle_t;

   // alt selects SUB/SRA; callers must only set it where the encoding allows
   function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_idu_stage_if.sv
// rtl/ysyx_idu_stage_if.sv - fetch-side and execute-side handshake bundle of the decode stage
interface ysyx_idu_stage_if #(
   parameter int XLEN  = 32,
   parameter int ALU_W = 4
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_inst;
   logic [XLEN-1:0]  in_pc;

   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_pc;
   logic [XLEN-1:0]  out_imm;
   logic [4:0]       out_rs1;
   logic [4:0]       out_rs2;
   logic [4:0]       out_rd;
   logic             out_rf_wr_en;
   logic [1:0]       out_rf_wr_sel;
   logic             out_do_jump;
   logic             out_is_branch;
   logic             out_mem_rd;
   logic             out_mem_wr;
   logic             out_alu_a_sel;
   logic             out_alu_b_sel;
   logic [ALU_W-1:0] out_alu_ctrl;
   logic [2:0]       out_funct3;
   logic             out_ebreak;
   logic             out_illegal;

   modport master (
      output flush, in_valid, in_inst, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
             out_rf_wr_en, out_rf_wr_sel, out_do_jump, out_is_branch,
             out_mem_rd, out_mem_wr, out_alu_a_sel, out_alu_b_sel,
             out_alu_ctrl, out_funct3, out_ebreak, out_illegal
   );

   modport slave (
      input  flush, in_valid, in_inst, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
             out_rf_wr_en, out_rf_wr_sel, out_do_jump, out_is_branch,
             out_mem_rd, out_mem_wr, out_alu_a_sel, out_alu_b_sel,
             out_alu_ctrl, out_funct3, out_ebreak, out_illegal
   );
endinterface

// File: rtl/ysyx_idu_dec.sv
// rtl/ysyx_idu_dec.sv - combinational RV32 decoder with immediate extension
module ysyx_idu_dec
   import ysyx_pkg::*;
(
   input  logic [31:0]  inst,
   input  logic [31:0]  pc,
   output dec_bundle_t  bundle
);
   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        legal;
   logic        wr;
   dec_bundle_t d;

   assign opc = inst[6:0];
   assign f3  = inst[14:12];
   assign f7  = inst[31:25];

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   always_comb begin
      d           = '0;
      d.pc        = pc;
      d.rs1       = inst[19:15];
      d.rs2       = inst[24:20];
      d.rd        = inst[11:7];
      d.funct3    = f3;
      d.alu_ctrl  = ALU_ADD;
      d.rf_wr_sel = WB_ALU;
      legal       = 1'b0;
      wr          = 1'b0;
      case (opc)
         OPC_LUI: begin
            legal = 1'b1; wr = 1'b1; d.imm = imm_u;
            d.alu_ctrl = ALU_PASSB; d.alu_a_sel = 1'b1; d.alu_b_sel = 1'b1;
         end
         OPC_AUIPC: begin
            legal = 1'b1; wr = 1'b1; d.imm = imm_u; d.alu_b_sel = 1'b1;
         end
         OPC_JAL: begin
            legal = 1'b1; wr = 1'b1; d.imm = imm_j; d.do_jump = 1'b1;
            d.rf_wr_sel = WB_PC4; d.alu_b_sel = 1'b1;
         end
         OPC_JALR: begin
            legal = (f3 == 3'b000); wr = 1'b1; d.imm = imm_i; d.do_jump = 1'b1;
            d.rf_wr_sel = WB_PC4; d.alu_a_sel = 1'b1; d.alu_b_sel = 1'b1;
         end
         OPC_BRANCH: begin
            legal = (f3 != 3'b010) && (f3 != 3'b011);
            d.imm = imm_b; d.is_branch = 1'b1; d.alu_ctrl = ALU_BR; d.alu_a_sel = 1'b1;
         end
         OPC_LOAD: begin
            legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            wr = 1'b1; d.imm = imm_i; d.mem_rd = 1'b1; d.rf_wr_sel = WB_MEM;
            d.alu_a_sel = 1'b1; d.alu_b_sel = 1'b1;
         end
         OPC_STORE: begin
            legal = !f3[2] && (f3 != 3'b011);
            d.imm = imm_s; d.mem_wr = 1'b1; d.alu_a_sel = 1'b1; d.alu_b_sel = 1'b1;
         end
         OPC_OPIMM: begin
            // shift-immediates reuse funct7 space; only srai may set bit 30
            if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
            else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            else                   legal = 1'b1;
            wr = 1'b1; d.imm = imm_i; d.alu_a_sel = 1'b1; d.alu_b_sel = 1'b1;
            d.alu_ctrl = alu_from_f3(f3, (f3 == 3'b101) && f7[5]);
         end
         OPC_OP: begin
            legal = (f7 == 7'b0000000) ||
                    ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
            wr = 1'b1; d.alu_a_sel = 1'b1;
            d.alu_ctrl = alu_from_f3(f3, f7[5]);
         end
         OPC_SYSTEM: begin
            legal    = (inst == INST_EBREAK);
            d.ebreak = legal;
         end
         default: ;
      endcase

      d.rf_wr_en = wr && (d.rd != 5'd0);

      if (!legal) begin
         d           = '0;
         d.pc        = pc;
         d.rs1       = inst[19:15];
         d.rs2       = inst[24:20];
         d.rd        = inst[11:7];
         d.funct3    = f3;
         d.alu_ctrl  = ALU_ADD;
         d.rf_wr_sel = WB_ALU;
         d.illegal   = 1'b1;
      end
   end

   assign bundle = d;
endmodule

// File: rtl/ysyx_idu_stage.sv
// rtl/ysyx_idu_stage.sv - decode stage: decoder feeding a one- or two-entry output buffer
module ysyx_idu_stage
   import ysyx_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int SKID  = 1,
   parameter int ALU_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   ysyx_idu_stage_if.slave   bus
);
   dec_bundle_t dec;
   dec_bundle_t ent0_q, ent1_q;
   logic [1:0]  count_q, count_n;
   logic        in_ready_q;
   logic        in_ready_int;
   logic        out_valid_int;
   logic        push, pop;

   ysyx_idu_dec u_dec (
      .inst   (bus.in_inst),
      .pc     (32'(bus.in_pc)),
      .bundle (dec)
   );

   // two-entry mode keeps in_ready registered so out_ready never reaches it combinationally
   assign out_valid_int = (count_q != 2'd0);
   assign in_ready_int  = (SKID != 0) ? in_ready_q : (!out_valid_int || bus.out_ready);
   assign push          = bus.in_valid && in_ready_int && !bus.flush;
   assign pop           = out_valid_int && bus.out_ready;

   always_comb begin
      count_n = count_q;
      if (push && !pop)      count_n = count_q + 2'd1;
      else if (pop && !push) count_n = count_q - 2'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q    <= 2'd0;
         ent0_q     <= '0;
         ent1_q     <= '0;
         in_ready_q <= 1'b1;
      end else if (bus.flush) begin
         count_q    <= 2'd0;
         ent0_q     <= '0;
         ent1_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         count_q    <= count_n;
         in_ready_q <= (count_n != 2'd2);
         if (pop && (count_q == 2'd2))
            ent0_q <= ent1_q;
         // head slot takes the new entry whenever it is (or is becoming) free
         if (push) begin
            if ((count_q == 2'd0) || ((count_q == 2'd1) && pop))
               ent0_q <= dec;
            else
               ent1_q <= dec;
         end
      end
   end

   assign bus.in_ready      = in_ready_int;
   assign bus.out_valid     = out_valid_int;
   assign bus.out_pc        = XLEN'(ent0_q.pc);
   assign bus.out_imm       = XLEN'(ent0_q.imm);
   assign bus.out_rs1       = ent0_q.rs1;
   assign bus.out_rs2       = ent0_q.rs2;
   assign bus.out_rd        = ent0_q.rd;
   assign bus.out_rf_wr_en  = ent0_q.rf_wr_en;
   assign bus.out_rf_wr_sel = ent0_q.rf_wr_sel;
   assign bus.out_do_jump   = ent0_q.do_jump;
   assign bus.out_is_branch = ent0_q.is_branch;
   assign bus.out_mem_rd    = ent0_q.mem_rd;
   assign bus.out_mem_wr    = ent0_q.mem_wr;
   assign bus.out_alu_a_sel = ent0_q.alu_a_sel;
   assign bus.out_alu_b_sel = ent0_q.alu_b_sel;
   assign bus.out_alu_ctrl  = ALU_W'(ent0_q.alu_ctrl);
   assign bus.out_funct3    = ent0_q.funct3;
   assign bus.out_ebreak    = ent0_q.ebreak;
   assign bus.out_illegal   = ent0_q.illegal;
endmodule
